// File: rtl/jeff_tdm_demux8.sv
// Receive end of an 8:1 mux-based TDM link: counts slots locked to a frame
// sync and rebuilds each serial frame into a registered 8-bit word.
module jeff_tdm_demux8 #(
  parameter int NUM_SLOTS = 8,
  parameter bit INVERT_IN = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sync,
  input  logic       din,
  output logic [7:0] q,
  output logic       valid,
  output logic [2:0] slot,
  output logic       locked,
  output logic       err
);

  localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [6:0] shadow;
  logic [6:0] shadow_nxt;
  logic [2:0] slot_nxt;
  logic [7:0] q_nxt;
  logic       valid_nxt;
  logic       err_nxt;
  logic       bit_in;

  // Undo the inversion of the mux's W output so bits always match Dk.
  function automatic logic cond_bit(input logic d);
    return d ^ INVERT_IN;
  endfunction

  assign bit_in = cond_bit(din);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        HUNT:    if (sync) state_nxt = RUN;
        RUN:     if ((slot == 3'd0) && !sync) state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Slot steering: a sync anywhere but slot 0 restarts the frame at slot 1,
  // and a missing sync at slot 0 drops lock. Stale shadow bits left by a
  // discarded frame are always overwritten before the next capture.
  always_comb begin
    slot_nxt   = slot;
    shadow_nxt = shadow;
    q_nxt      = q;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          if (sync) begin
            shadow_nxt[0] = bit_in;
            slot_nxt      = 3'd1;
          end else begin
            slot_nxt = 3'd0;
          end
        end
        RUN: begin
          if (slot == 3'd0) begin
            if (sync) begin
              shadow_nxt[0] = bit_in;
              slot_nxt      = 3'd1;
            end else begin
              err_nxt  = 1'b1;
              slot_nxt = 3'd0;
            end
          end else if (sync) begin
            err_nxt       = 1'b1;
            shadow_nxt[0] = bit_in;
            slot_nxt      = 3'd1;
          end else if (slot == LAST_SLOT) begin
            q_nxt     = {bit_in, shadow};
            valid_nxt = 1'b1;
            slot_nxt  = 3'd0;
          end else begin
            shadow_nxt[slot] = bit_in;
            slot_nxt         = slot + 3'd1;
          end
        end
        default: slot_nxt = 3'd0;
      endcase
    end
  end

  assign locked = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot   <= 3'd0;
      shadow <= 7'd0;
      q      <= 8'h00;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      slot   <= slot_nxt;
      shadow <= shadow_nxt;
      q      <= q_nxt;
      valid  <= valid_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_jeff_tdm_demux8.sv
// Bench for jeff_tdm_demux8: plain and inverting instances share the stimulus;
// a scoreboard pairs every expected frame with the next valid strobe.
module tb_jeff_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic       din = 1'b0;
  logic [7:0] q, qi;
  logic       valid, vi, locked, li, err, ei;
  logic [2:0] slot, si;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int err_before;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_qi[$];

  typedef struct {
    logic [7:0] raw;
    logic [7:0] exp;
    logic [7:0] exp_inv;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  jeff_tdm_demux8 #(.NUM_SLOTS(8), .INVERT_IN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .din(din),
    .q(q), .valid(valid), .slot(slot), .locked(locked), .err(err)
  );

  jeff_tdm_demux8 #(.NUM_SLOTS(8), .INVERT_IN(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .din(din),
    .q(qi), .valid(vi), .slot(si), .locked(li), .err(ei)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%02h required 0x%02h at %0t", name, act, req, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are read 1 ns after the rising edge.
  task automatic drv(input logic e, input logic s, input logic d);
    @(negedge clk);
    en = e;
    sync = s;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] raw, input logic [7:0] e_q,
                            input logic [7:0] e_qi, input bit gaps);
    exp_q.push_back(e_q);
    exp_qi.push_back(e_qi);
    for (int k = 0; k < 8; k++) begin
      check("slot", 8'(slot), 8'(k));
      if (k > 0) check("locked", 8'(locked), 8'h01);
      drv(1'b1, k == 0, raw[k]);
      if (gaps) begin
        for (int g = 0; g < (k % 3) + 1; g++) begin
          drv(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          check("slot_hold", 8'(slot), 8'((k + 1) % 8));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (err) err_cnt++;
    if (valid) begin
      check("valid_back_to_back", 8'(prev_valid), 8'h00);
      check("valid_err_overlap", 8'(err), 8'h00);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: q=0x%02h with no frame expected at %0t", q, $time);
      end else begin
        check("q", q, exp_q.pop_front());
      end
    end
    if (vi) begin
      if (exp_qi.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid_inv: q=0x%02h with no frame expected at %0t", qi, $time);
      end else begin
        check("q_inv", qi, exp_qi.pop_front());
      end
    end
    prev_valid = valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      vecs[k].raw     = 8'h01 << k;
      vecs[k].exp     = 8'h01 << k;
      vecs[k].exp_inv = ~(8'h01 << k);
    end
    vecs[8] = '{raw: 8'h65, exp: 8'h65, exp_inv: 8'h9A};
    vecs[9] = '{raw: 8'hFF, exp: 8'hFF, exp_inv: 8'h00};

    // Reset state
    #12;
    check("rst_q", q, 8'h00);
    check("rst_q_inv", qi, 8'h00);
    check("rst_valid", 8'(valid), 8'h00);
    check("rst_slot", 8'(slot), 8'h00);
    check("rst_locked", 8'(locked), 8'h00);
    check("rst_err", 8'(err), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Walking ones, inverted pattern, all ones: back-to-back frames
    foreach (vecs[i]) send_frame(vecs[i].raw, vecs[i].exp, vecs[i].exp_inv, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    check("locked_hold_en0", 8'(locked), 8'h01);

    // en gaps with toggling sync/din
    err_before = err_cnt;
    send_frame(8'hC3, 8'hC3, 8'h3C, 1'b1);
    drv(1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    check("en_gap_err_count", 8'(err_cnt - err_before), 8'h00);

    // Missing sync at slot 0
    send_frame(8'h55, 8'h55, 8'hAA, 1'b0);
    drv(1'b1, 1'b0, 1'b1);
    check("miss_err", 8'(err), 8'h01);
    check("miss_locked", 8'(locked), 8'h00);
    check("miss_slot", 8'(slot), 8'h00);
    check("miss_q", q, 8'h55);
    drv(1'b1, 1'b0, 1'b0);
    check("hunt_err", 8'(err), 8'h00);
    check("hunt_slot", 8'(slot), 8'h00);
    drv(1'b0, 1'b1, 1'b1);
    check("hunt_en0_locked", 8'(locked), 8'h00);
    send_frame(8'hA7, 8'hA7, 8'h58, 1'b0);

    // Early sync at slot 4 restarts the frame
    drv(1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 4; k++) drv(1'b1, 1'b0, 1'b1);
    check("early_pre_slot", 8'(slot), 8'h04);
    exp_q.push_back(8'hF0);
    exp_qi.push_back(8'h0F);
    drv(1'b1, 1'b1, 1'b0);
    check("early_err", 8'(err), 8'h01);
    check("early_valid", 8'(valid), 8'h00);
    check("early_slot", 8'(slot), 8'h01);
    check("early_locked", 8'(locked), 8'h01);
    for (int k = 1; k < 8; k++) begin
      check("early_run_slot", 8'(slot), 8'(k));
      drv(1'b1, 1'b0, k >= 4);
    end

    // Asynchronous reset mid-frame
    drv(1'b1, 1'b1, 1'b1);
    for (int k = 1; k < 5; k++) drv(1'b1, 1'b0, 1'b0);
    check("pre_rst_slot", 8'(slot), 8'h05);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_q", q, 8'h00);
    check("arst_q_inv", qi, 8'h00);
    check("arst_valid", 8'(valid), 8'h00);
    check("arst_slot", 8'(slot), 8'h00);
    check("arst_locked", 8'(locked), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 1'b0, 1'b1);
      check("post_rst_locked", 8'(locked), 8'h00);
      check("post_rst_slot", 8'(slot), 8'h00);
    end
    send_frame(8'h3C, 8'h3C, 8'hC3, 1'b0);

    drv(1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    check("sb_drain", 8'(exp_q.size()), 8'h00);
    check("sb_drain_inv", 8'(exp_qi.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
